// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit; ports clk, rst, start, op, op1, op2, annul -> busy, stall_req, hi_out, lo_out, hilo_en_out; divider present only with EX_MULDIV_DIV_EN
module ex_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              annul,
  output logic              busy,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              hilo_en_out
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] m2, a1, a2;
  logic [2*DATA_W-1:0] acc, nx, res, mul_nx, mul_fix;
  logic [DATA_W:0] sum;
  logic [CW-1:0] cnt;
  logic neg_lo, sgn, n1, n2;
  always_comb begin
    sgn = ~op[0];
    n1 = sgn & op1[DATA_W-1];
    n2 = sgn & op2[DATA_W-1];
    a1 = n1 ? -op1 : op1;
    a2 = n2 ? -op2 : op2;
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, acc[0] ? m2 : {DATA_W{1'b0}}};
    mul_nx = {sum, acc[DATA_W-1:1]};
    mul_fix = neg_lo ? -mul_nx : mul_nx;
  end
`ifdef EX_MULDIV_DIV_EN
  logic neg_hi, ge;
  logic [DATA_W:0] sh, diff;
  logic [DATA_W-1:0] rn, q, r;
  logic [2*DATA_W-1:0] div_nx;
  always_comb begin
    sh = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    diff = sh - {1'b0, m2};
    ge = sh >= {1'b0, m2};
    rn = ge ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
    div_nx = {rn, acc[DATA_W-2:0], ge};
    q = neg_lo ? -div_nx[DATA_W-1:0] : div_nx[DATA_W-1:0];
    r = neg_hi ? -rn : rn;
    nx = state == DIV ? div_nx : mul_nx;
    res = state == DIV ? {r, q} : mul_fix;
  end
`else
  assign nx = mul_nx;
  assign res = mul_fix;
`endif
  assign stall_req = (start && state == IDLE && !annul && !rst) || busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      hilo_en_out <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      acc <= '0;
      m2 <= '0;
      cnt <= '0;
      neg_lo <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
      neg_hi <= 1'b0;
`endif
    end else if (annul) begin
      state <= IDLE;
      busy <= 1'b0;
      hilo_en_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hilo_en_out <= 1'b0;
          if (start) begin
            cnt <= '0;
            m2 <= a2;
            neg_lo <= n1 ^ n2;
            acc <= {{DATA_W{1'b0}}, a1};
            busy <= 1'b1;
            state <= MUL;
`ifdef EX_MULDIV_DIV_EN
            neg_hi <= n1;
            if (op[1]) begin
              state <= DIV;
              // Divide by zero: preload so the single remaining step yields rem=op1, quo=all ones
              if (op2 == '0) begin
                cnt <= CW'(DATA_W - 1);
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                acc <= {1'b0, op1, {(DATA_W-1){1'b1}}};
              end
            end
`else
            // No divider: one zero multiply step gives the all-zero DIV result
            if (op[1]) begin
              cnt <= CW'(DATA_W - 1);
              m2 <= '0;
              neg_lo <= 1'b0;
              acc <= '0;
            end
`endif
          end
        end
        MUL, DIV: begin
          acc <= nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            hilo_en_out <= 1'b1;
            {hi_out, lo_out} <= res;
          end
        end
        default: begin
          state <= IDLE;
          hilo_en_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: vector table, corner sequences and random ops against an arithmetic model
module tb_ex_muldiv;
  localparam int W = 32;
`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, annul = 1'b0;
  logic [1:0] op = '0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic busy, stall_req, hilo_en_out;
  logic [W-1:0] hi_out, lo_out;
  int checks = 0, errors = 0;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
  } vec_t;
  vec_t tbl[10];
  always #5 clk = ~clk;
  ex_muldiv #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op1(op1), .op2(op2), .annul(annul),
    .busy(busy), .stall_req(stall_req), .hi_out(hi_out), .lo_out(lo_out), .hilo_en_out(hilo_en_out)
  );
  function automatic logic [63:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint sq, sr;
    if (!o[1]) return o[0] ? {32'b0, a} * {32'b0, b} : 64'(sa * sb);
    if (!DIV_EN) return 64'd0;
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (o[0]) return {a % b, a / b};
    sq = sa / sb;
    sr = sa % sb;
    return {sr[31:0], sq[31:0]};
  endfunction
  function automatic int lat(logic [1:0] o, logic [31:0] b);
    return (o[1] && (!DIV_EN || b == 0)) ? 2 : W + 1;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Called just after a negedge; returns just after a negedge
  task automatic run(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [63:0] e, string name);
    int l = lat(o, b);
    int bad = 0;
    op = o; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    #1 chk({name, " stall_on_start"}, 64'(stall_req), 64'd1);
    @(posedge clk);
    #1 start = 1'b0; op = 2'($urandom); op1 = $urandom; op2 = $urandom;
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      start = (k == 3 || k == l);
      #1;
      if (busy !== (k < l)) bad++;
      if (stall_req !== (k < l)) bad++;
      if (hilo_en_out !== (k == l)) bad++;
      if (k == l) chk({name, " result"}, {hi_out, lo_out}, e);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    if (busy !== 1'b0 || hilo_en_out !== 1'b0 || stall_req !== 1'b0) bad++;
    if ({hi_out, lo_out} !== e) bad++;
    chk({name, " timing"}, 64'(bad), 64'd0);
  endtask
  initial begin
    int pulses, bad;
    logic [1:0] o;
    logic [31:0] a, b;
    tbl[0] = '{2'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1};
    tbl[1] = '{2'd1, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE};
    tbl[2] = '{2'd2, 32'hFFFFFFF9, 32'd2, DIV_EN ? 64'hFFFFFFFF_FFFFFFFD : 64'd0};
    tbl[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 64'h00000000_80000000 : 64'd0};
    tbl[4] = '{2'd3, 32'd7, 32'd0, DIV_EN ? 64'h00000007_FFFFFFFF : 64'd0};
    tbl[5] = '{2'd1, 32'd3, 32'd4, 64'd12};
    tbl[6] = '{2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tbl[7] = '{2'd0, 32'd7, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9};
    tbl[8] = '{2'd3, 32'd100, 32'd7, DIV_EN ? 64'h00000002_0000000E : 64'd0};
    tbl[9] = '{2'd2, 32'd7, 32'hFFFFFFFE, DIV_EN ? 64'h00000001_FFFFFFFD : 64'd0};
    start = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset ctl", {61'd0, busy, stall_req, hilo_en_out}, 64'd0);
    chk("reset hilo", {hi_out, lo_out}, 64'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, $sformatf("vec%0d", i));
    // annul a DIVU at N+10, new MULTU accepted at N+11
    op = 2'd3; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0; bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1 pulses += int'(hilo_en_out);
      if (DIV_EN && busy !== 1'b1) bad++;
      if (k == 10) annul = 1'b1;
    end
    @(negedge clk);
    annul = 1'b0;
    #1 chk("annul busy", 64'(busy), 64'd0);
    chk("annul strobes", 64'(pulses + int'(hilo_en_out)), DIV_EN ? 64'd0 : 64'd1);
    chk("annul busy before", 64'(bad), 64'd0);
    run(2'd1, 32'd3, 32'd4, 64'd12, "after_annul");
    // annul and start together
    op = 2'd0; op1 = 32'd5; op2 = 32'd5; start = 1'b1; annul = 1'b1;
    #1 chk("annul+start stall", 64'(stall_req), 64'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      #1 pulses += int'(hilo_en_out) + int'(busy);
    end
    chk("annul+start ignored", 64'(pulses), 64'd0);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = $urandom_range(1, 20);
        default: ;
      endcase
      run(o, a, b, model(o, a, b), $sformatf("rnd%0d", i));
    end
    run(2'd1, 32'd3, 32'd4, 64'd12, "pre_reset");
    // reset at N+5 of a MULT, with an ignored start while busy
    op = 2'd0; op1 = 32'd5; op2 = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = (k == 2);
      op1 = 32'd9;
      if (k == 5) rst = 1'b1;
      #1 if (k == 2) chk("busy start ignored", {62'd0, busy, stall_req}, 64'd3);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst ctl", {61'd0, busy, stall_req, hilo_en_out}, 64'd0);
    chk("midrst hilo", {hi_out, lo_out}, 64'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1 pulses += int'(hilo_en_out) + int'(busy);
    end
    chk("midrst no strobe", 64'(pulses), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/HI/LO width (even, >=8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high (asserted == `RstEnable).
REQ-004 SHALL have port start  input  1  request a new operation this cycle.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port op1  input  DATA_W  multiplicand / dividend.
REQ-007 SHALL have port op2  input  DATA_W  multiplier / divisor.
REQ-008 SHALL have port annul  input  1  pipeline flush; abandon current operation.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port stall_req  output  1  hold upstream pipeline.
REQ-011 SHALL have port hi_out  output  DATA_W  product high half / remainder.
REQ-012 SHALL have port lo_out  output  DATA_W  product low half / quotient.
REQ-013 SHALL have port hilo_en_out  output  1  one-cycle HI/LO write strobe (done).

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset and annul force IDLE.
REQ-015 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-016 SHALL latch op, op1, op2 on acceptance; later input changes SHALL NOT affect the result.
REQ-017 SHALL, for signed ops, operate on magnitudes (two's-complement negate of negative operands) and fix sign at completion.
REQ-018 SHALL perform MULT/MULTU as iterative shift-add, one bit per cycle, DATA_W iterations, 2*DATA_W-bit result {hi,lo}.
REQ-019 SHALL perform DIV/DIVU as iterative restoring division, one bit per cycle, DATA_W iterations; lo=quotient, hi=remainder.
REQ-020 SHALL give signed quotient sign = op1 sign XOR op2 sign, remainder sign = op1 sign.
REQ-021 SHALL wrap signed most-negative / -1: lo = most-negative value, hi = 0.
REQ-022 SHALL, on divisor 0, skip iteration: DONE one cycle after acceptance, lo = all ones, hi = op1 unchanged.
REQ-023 SHALL, for start accepted in cycle N, assert busy cycles N+1..N+DATA_W and hilo_en_out in cycle N+DATA_W+1 only (DONE state), busy low in DONE.
REQ-024 SHALL hold hi_out/lo_out valid during the hilo_en_out cycle and keep them stable until the next acceptance.
REQ-025 SHALL drive stall_req = (start AND state==IDLE AND NOT annul) OR busy; deasserted in DONE.
REQ-026 SHALL, on annul in any state, return to IDLE next cycle with no hilo_en_out; annul and start together: annul wins.
REQ-027 SHALL return from DONE to IDLE next cycle; start during DONE ignored.

Reset
REQ-028 SHALL, while rst is high at a clock edge, enter IDLE and clear busy, stall_req, hilo_en_out, hi_out, lo_out and all iteration state to 0.
REQ-029 SHALL, on rst mid-operation, discard the operation with no hilo_en_out.

Configuration
REQ-030 SHALL compile the divider only when EX_MULDIV_DIV_EN is defined.
REQ-031 SHALL, without EX_MULDIV_DIV_EN, complete DIV/DIVU in DONE one cycle after acceptance with hi_out = lo_out = 0 and no divider logic; MULT/MULTU unaffected.

Verification (DATA_W=32)
REQ-032 SHALL cover MULT op1=0xFFFFFFFD (-3), op2=5 -> hilo_en_out at N+33, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 SHALL cover MULTU op1=0xFFFFFFFF, op2=2 -> hi=0x00000001, lo=0xFFFFFFFE; busy high exactly N+1..N+32.
REQ-034 SHALL cover DIV op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 SHALL cover DIVU op1=7, op2=0 -> hilo_en_out at N+2, lo=0xFFFFFFFF, hi=0x00000007.
REQ-036 SHALL cover DIVU started at N, annul at N+10 -> no hilo_en_out, busy low at N+11, new MULTU 3*4 accepted at N+11 -> lo=12, hi=0.
REQ-037 SHALL cover rst at N+5 of a MULT and start ignored while busy -> all outputs 0, no strobe.
